// File: rtl/step_clock_pkg.sv
// Shared constants and types for the step clock source: operating modes,
// debounce FSM states and the smallest usable free-run divisor.
package step_clock_pkg;

    localparam logic [1:0] MODE_PAUSE = 2'b00;
    localparam logic [1:0] MODE_FREE  = 2'b01;
    localparam logic [1:0] MODE_STEP  = 2'b10;
    localparam logic [1:0] MODE_RSVD  = 2'b11;

    localparam int MIN_DIVISOR = 2;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_WAIT = 2'd1,
        PRESSED    = 2'd2,
        REL_WAIT   = 2'd3
    } db_state_e;

endpackage

// File: rtl/step_clock_source_debouncer.sv
// Push-button synchronizer plus debounce FSM; emits one step_req cycle per
// accepted press, combinationally in the cycle the press is accepted.
module step_debouncer
    import step_clock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_button,
    output logic o_step_req
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_next;
    db_state_e              r_state;
    db_state_e              w_state_next;
    logic                   w_s;
    logic                   w_cnt_done;
    logic                   w_step_req;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_button};
        end
    end

    assign w_s        = r_sync[SYNC_STAGES-1];
    assign w_cnt_done = (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

    // Starting in REL_WAIT means a button already held at reset release
    // lands in PRESSED without ever passing through PRESS_WAIT.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= REL_WAIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_s) begin
                    w_state_next = PRESS_WAIT;
                    w_cnt_next   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!w_s) begin
                    w_state_next = IDLE;
                    w_cnt_next   = '0;
                end else if (w_cnt_done) begin
                    w_state_next = PRESSED;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!w_s) begin
                    w_state_next = REL_WAIT;
                    w_cnt_next   = '0;
                end
            end
            REL_WAIT: begin
                if (w_s) begin
                    w_state_next = PRESSED;
                    w_cnt_next   = '0;
                end else if (w_cnt_done) begin
                    w_state_next = IDLE;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_next = IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        w_step_req = 1'b0;
        if ((r_state == PRESS_WAIT) && w_s && w_cnt_done) begin
            w_step_req = 1'b1;
        end
    end

    assign o_step_req = w_step_req;

endmodule

// File: rtl/step_clock_source.sv
// Clock-edge source for the ripple-counter circuits: free-running prescaled
// pulses, debounced single steps, or pause, plus a modulo pulse count.
module step_clock_source
    import step_clock_pkg::*;
#(
    parameter int DIV_WIDTH       = 16,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int SYNC_STAGES     = 2,
    parameter int COUNT_WIDTH     = 3
) (
    input  logic                   input_clock1_1,
    input  logic                   input_reset_n,
    input  logic [1:0]             input_mode,
    input  logic [DIV_WIDTH-1:0]   input_divisor,
    input  logic                   input_step_button,
    output logic                   output_step_clock,
    output logic [COUNT_WIDTH-1:0] output_step_count,
    output logic                   output_running
);

    logic [1:0]             r_mode;
    logic [1:0]             r_mode_prev;
    logic [DIV_WIDTH-1:0]   r_cnt;
    logic                   r_step_clock;
    logic [COUNT_WIDTH-1:0] r_step_count;

    logic [DIV_WIDTH-1:0]   w_eff;
    logic                   w_wrap;
    logic                   w_tick;
    logic [DIV_WIDTH-1:0]   w_cnt_next;
    logic                   w_step_req;
    logic                   w_fire;

    step_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .SYNC_STAGES     (SYNC_STAGES)
    ) u_debouncer (
        .i_clk      (input_clock1_1),
        .i_rst_n    (input_reset_n),
        .i_button   (input_step_button),
        .o_step_req (w_step_req)
    );

    // r_mode_prev lets the prescaler see the first cycle of free-run.
    always_ff @(posedge input_clock1_1 or negedge input_reset_n) begin
        if (!input_reset_n) begin
            r_mode      <= MODE_PAUSE;
            r_mode_prev <= MODE_PAUSE;
        end else begin
            r_mode      <= input_mode;
            r_mode_prev <= r_mode;
        end
    end

    always_comb begin
        w_eff = input_divisor;
        if (input_divisor < DIV_WIDTH'(MIN_DIVISOR)) begin
            w_eff = DIV_WIDTH'(MIN_DIVISOR);
        end
    end

    // ">=" rather than "==" so a divisor cut below the running count wraps at once.
    assign w_wrap = (r_cnt >= (w_eff - DIV_WIDTH'(1)));

    always_comb begin
        w_tick     = 1'b0;
        w_cnt_next = r_cnt;
        case (r_mode)
            MODE_FREE: begin
                if (r_mode_prev != MODE_FREE) begin
                    w_cnt_next = '0;
                end else if (w_wrap) begin
                    w_tick     = 1'b1;
                    w_cnt_next = '0;
                end else begin
                    w_cnt_next = r_cnt + DIV_WIDTH'(1);
                end
            end
            MODE_STEP: begin
                w_cnt_next = '0;
            end
            MODE_PAUSE, MODE_RSVD: begin
                w_cnt_next = r_cnt;
            end
        endcase
    end

    assign w_fire = w_tick | ((r_mode == MODE_STEP) & w_step_req);

    always_ff @(posedge input_clock1_1 or negedge input_reset_n) begin
        if (!input_reset_n) begin
            r_cnt        <= '0;
            r_step_clock <= 1'b0;
            r_step_count <= '0;
        end else begin
            r_cnt        <= w_cnt_next;
            r_step_clock <= w_fire;
            if (w_fire) begin
                r_step_count <= r_step_count + COUNT_WIDTH'(1);
            end
        end
    end

    assign output_step_clock = r_step_clock;
    assign output_step_count = r_step_count;
    assign output_running    = (r_mode == MODE_FREE);

endmodule
